// File: rtl/ir_sensor_scheduler_if.sv
// Interface bundle for ir_sensor_scheduler.
//   master : the scheduler (samples enable/ir_in, drives results and drive pins)
//   slave  : the host/register side and sensor pad side
// Signals:
//   enable       run sweeps while high
//   ir_in        sensor inputs, 0 = capacitor discharged (pre-synchronised)
//   ir_drive     charge drive, one-hot or zero
//   sample_value last measured discharge time
//   sample_ch    channel of sample_value
//   sample_valid one-cycle pulse per new sample
//   sweep_done   one-cycle pulse when the last channel was sampled
//   black        per-channel dark flag
interface ir_sensor_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 20
);
    localparam int CH_W = $clog2(N_CH);

    logic                enable;
    logic [N_CH-1:0]     ir_in;
    logic [N_CH-1:0]     ir_drive;
    logic [CNT_W-1:0]    sample_value;
    logic [CH_W-1:0]     sample_ch;
    logic                sample_valid;
    logic                sweep_done;
    logic [N_CH-1:0]     black;

    modport master (
        input  enable, ir_in,
        output ir_drive, sample_value, sample_ch, sample_valid, sweep_done, black
    );

    modport slave (
        output enable, ir_in,
        input  ir_drive, sample_value, sample_ch, sample_valid, sweep_done, black
    );
endinterface

// File: rtl/ir_sensor_scheduler.sv
// ir_sensor_scheduler: time-multiplexed RC-discharge IR floor sensor controller.
// One channel at a time is charged for CHARGE_CYCLES clocks, then its discharge
// time is counted (capped at TIMEOUT), then published for one STORE cycle.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    ir_sensor_scheduler_if.master (enable, ir_in in; ir_drive,
//          sample_value, sample_ch, sample_valid, sweep_done, black out)
// Optional build macro IR_DEBOUNCE_EN: black[ch] only sets after DEBOUNCE
// consecutive dark samples on that channel; a light sample clears it at once.
// Without it black[ch] is just the dark result of the channel's latest sample.
module ir_sensor_scheduler #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 20,
    parameter int CHARGE_CYCLES = 2048,
    parameter int TIMEOUT       = 2000,
    parameter int THRESHOLD     = 1200,
    parameter int DEBOUNCE      = 8
) (
    input  logic clock,
    input  logic reset,
    ir_sensor_scheduler_if.master bus
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CC_LAST = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
    localparam logic [31:0]      TH32    = 32'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, STORE} state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  ch, ch_nxt, ch_q;
    logic [CNT_W-1:0] cnt, cnt_nxt, meas_val, meas_nxt, value_q;
    logic [N_CH-1:0]  drive_q, drive_nxt, black_q;
    logic             valid_q, done_q, commit, last_ch, dark;

    assign last_ch = (ch == CH_W'(N_CH - 1));
    assign dark    = (32'(meas_val) >= TH32);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; enable is only looked at in IDLE and STORE so a
    // channel in flight always runs to completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.enable) state_nxt = CHARGE;
            CHARGE:  if (cnt == CC_LAST) state_nxt = MEASURE;
            MEASURE: if (!bus.ir_in[ch] || cnt == TO) state_nxt = STORE;
            STORE:   state_nxt = bus.enable ? CHARGE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values. The counter returns to 0 on every phase
    // change, so it only ever counts up within a phase and never wraps.
    always_comb begin
        cnt_nxt   = '0;
        meas_nxt  = meas_val;
        ch_nxt    = ch;
        drive_nxt = '0;
        commit    = 1'b0;
        case (state)
            CHARGE:  if (cnt != CC_LAST) cnt_nxt = cnt + CNT_W'(1);
            MEASURE: begin
                // Low input wins; at cnt==TIMEOUT both branches give TIMEOUT.
                if (!bus.ir_in[ch])  meas_nxt = cnt;
                else if (cnt == TO)  meas_nxt = TO;
                else                 cnt_nxt  = cnt + CNT_W'(1);
            end
            STORE: begin
                commit = 1'b1;
                ch_nxt = last_ch ? '0 : ch + CH_W'(1);
            end
            default: ;
        endcase
        // Drive is registered from the next state so it is high exactly
        // during the CHARGE_CYCLES clocks of the CHARGE state.
        if (state_nxt == CHARGE) drive_nxt[ch_nxt] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            meas_val <= '0;
            ch       <= '0;
            drive_q  <= '0;
            value_q  <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            meas_val <= meas_nxt;
            ch       <= ch_nxt;
            drive_q  <= drive_nxt;
            valid_q  <= commit;
            done_q   <= commit & last_ch;
            if (commit) begin
                value_q <= meas_val;
                ch_q    <= ch;
            end
        end
    end

    // Per-channel dark flag, updated on the same edge as sample_valid.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit, blk;
        assign hit        = commit && (ch == CH_W'(i));
        assign black_q[i] = blk;
`ifdef IR_DEBOUNCE_EN
        localparam int DBW = $clog2(DEBOUNCE + 1);
        localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE);
        logic [DBW-1:0] dbc;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                dbc <= '0;
                blk <= 1'b0;
            end else if (hit) begin
                if (!dark) begin
                    dbc <= '0;
                    blk <= 1'b0;
                end else if (dbc != DB_MAX) begin
                    dbc <= dbc + DBW'(1);
                    if (dbc + DBW'(1) == DB_MAX) blk <= 1'b1;
                end
            end
        end
`else
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)   blk <= 1'b0;
            else if (hit) blk <= dark;
        end
`endif
    end

    assign bus.ir_drive     = drive_q;
    assign bus.sample_value = value_q;
    assign bus.sample_ch    = ch_q;
    assign bus.sample_valid = valid_q;
    assign bus.sweep_done   = done_q;
    assign bus.black        = black_q;
endmodule

// File: tb/tb_ir_sensor_scheduler.sv
// Directed self-checking bench for ir_sensor_scheduler with N_CH=2,
// CHARGE_CYCLES=8, TIMEOUT=20, THRESHOLD=10, DEBOUNCE=3. Black-flag
// expectations follow IR_DEBOUNCE_EN when the bench is built with it.
module tb_ir_sensor_scheduler;
    localparam int N_CH = 2;
    localparam int CNT_W = 20;
`ifdef IR_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    ir_sensor_scheduler_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    ir_sensor_scheduler #(
        .N_CH(N_CH), .CNT_W(CNT_W), .CHARGE_CYCLES(8),
        .TIMEOUT(20), .THRESHOLD(10), .DEBOUNCE(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one channel: waits for its charge, counts drive-high clocks, lets
    // MEASURE run v cycles, optionally drops ir_in[ch], then steps through
    // STORE so the published outputs are visible on return.
    task automatic run_ch(input int ch, input int v, input bit low,
                          output logic [1:0] drv, output int hi,
                          output logic sv_store, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (bus.ir_drive === 2'b00 && n < 100) begin tick(); n++; end
        drv = bus.ir_drive;
        if (bus.ir_drive === 2'b00) ok = 1'b0;
        hi = 0;
        while (bus.ir_drive === drv && drv !== 2'b00 && hi < 100) begin tick(); hi++; end
        repeat (v) tick();
        if (low) bus.ir_in[ch] = 1'b0;
        tick();
        sv_store = bus.sample_valid;
        bus.ir_in = 2'b11;
        tick();
    endtask

    task automatic test_reset();
        bus.enable = 1'b0;
        bus.ir_in  = 2'b11;
        repeat (3) tick();
        checks++; if (bus.ir_drive !== 2'b00) begin errors++; $display("FAIL reset_drive: got %b expected 00", bus.ir_drive); end
        checks++; if (bus.sample_value !== 20'd0 || bus.sample_ch !== 1'b0) begin errors++; $display("FAIL reset_sample: got %0d/%0d expected 0/0", bus.sample_value, bus.sample_ch); end
        checks++; if (bus.sample_valid !== 1'b0 || bus.sweep_done !== 1'b0 || bus.black !== 2'b00) begin errors++; $display("FAIL reset_flags: got v=%b d=%b blk=%b expected 0 0 00", bus.sample_valid, bus.sweep_done, bus.black); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] drv; int hi; logic svs; bit ok;
        bus.enable = 1'b1;
        run_ch(0, 5, 1'b1, drv, hi, svs, ok);
        checks++; if (!ok || drv !== 2'b01) begin errors++; $display("FAIL basic_drive: got %b expected 01", drv); end
        checks++; if (hi !== 8) begin errors++; $display("FAIL basic_charge_len: got %0d expected 8", hi); end
        checks++; if (svs !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", svs); end
        checks++; if (bus.sample_valid !== 1'b1 || bus.sweep_done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got v=%b d=%b expected 1 0", bus.sample_valid, bus.sweep_done); end
        checks++; if (bus.sample_value !== 20'd5 || bus.sample_ch !== 1'b0) begin errors++; $display("FAIL basic_sample: got %0d ch%0d expected 5 ch0", bus.sample_value, bus.sample_ch); end
        checks++; if (bus.black[0] !== 1'b0) begin errors++; $display("FAIL basic_black0: got %b expected 0", bus.black[0]); end
        tick();
        checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", bus.sample_valid); end
    endtask

    task automatic test_timeout();
        logic [1:0] drv; int hi; logic svs; bit ok;
        run_ch(1, 20, 1'b0, drv, hi, svs, ok);
        checks++; if (!ok || drv !== 2'b10) begin errors++; $display("FAIL timeout_drive: got %b expected 10", drv); end
        checks++; if (svs !== 1'b0 || bus.sample_valid !== 1'b1) begin errors++; $display("FAIL timeout_len: got store=%b valid=%b expected 0 1", svs, bus.sample_valid); end
        checks++; if (bus.sample_value !== 20'd20 || bus.sample_ch !== 1'b1) begin errors++; $display("FAIL timeout_sample: got %0d ch%0d expected 20 ch1", bus.sample_value, bus.sample_ch); end
        checks++; if (bus.sweep_done !== 1'b1) begin errors++; $display("FAIL timeout_sweep_done: got %b expected 1", bus.sweep_done); end
        checks++; if (bus.black[1] !== !DB) begin errors++; $display("FAIL timeout_black1: got %b expected %b", bus.black[1], !DB); end
        checks++; if (bus.ir_drive !== 2'b01) begin errors++; $display("FAIL timeout_wrap: got %b expected 01", bus.ir_drive); end
    endtask

    task automatic test_debounce();
        logic [1:0] drv; int hi; logic svs; bit ok;
        logic exp_blk [3];
        exp_blk[0] = DB ? 1'b0 : 1'b1;
        exp_blk[1] = 1'b1;
        exp_blk[2] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            run_ch(0, 0, 1'b1, drv, hi, svs, ok);
            run_ch(1, (s == 2) ? 4 : 20, s == 2, drv, hi, svs, ok);
            checks++; if (bus.black[1] !== exp_blk[s]) begin errors++; $display("FAIL debounce_black1_sweep%0d: got %b expected %b", s + 2, bus.black[1], exp_blk[s]); end
        end
        checks++; if (bus.sample_value !== 20'd4) begin errors++; $display("FAIL debounce_light_value: got %0d expected 4", bus.sample_value); end
    endtask

    task automatic test_zero();
        logic [1:0] drv; int hi; logic svs; bit ok;
        bus.ir_in[0] = 1'b0;
        run_ch(0, 0, 1'b1, drv, hi, svs, ok);
        checks++; if (svs !== 1'b0 || bus.sample_valid !== 1'b1) begin errors++; $display("FAIL zero_len: got store=%b valid=%b expected 0 1", svs, bus.sample_valid); end
        checks++; if (bus.sample_value !== 20'd0 || bus.sample_ch !== 1'b0) begin errors++; $display("FAIL zero_value: got %0d ch%0d expected 0 ch0", bus.sample_value, bus.sample_ch); end
        run_ch(1, 2, 1'b1, drv, hi, svs, ok);
        checks++; if (bus.black !== 2'b00) begin errors++; $display("FAIL zero_light_black: got %b expected 00", bus.black); end
    endtask

    task automatic test_enable_drop();
        logic [1:0] drv; int hi; logic svs; bit ok; logic any;
        bus.enable = 1'b0;
        run_ch(0, 3, 1'b1, drv, hi, svs, ok);
        checks++; if (bus.sample_valid !== 1'b1 || bus.sample_value !== 20'd3 || bus.sample_ch !== 1'b0) begin errors++; $display("FAIL drop_completes: got v=%b %0d ch%0d expected 1 3 ch0", bus.sample_valid, bus.sample_value, bus.sample_ch); end
        any = |bus.ir_drive;
        repeat (4) begin tick(); any |= |bus.ir_drive; end
        checks++; if (any !== 1'b0) begin errors++; $display("FAIL drop_idle_drive: got %b expected 0", any); end
        bus.enable = 1'b1;
        tick();
        checks++; if (bus.ir_drive !== 2'b10) begin errors++; $display("FAIL drop_resume_ch1: got %b expected 10", bus.ir_drive); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] drv; int hi; logic svs; bit ok; logic any; int n;
        n = 0;
        while (bus.ir_drive !== 2'b00 && n < 50) begin tick(); n++; end
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.sample_value !== 20'd0 || bus.sample_ch !== 1'b0 || bus.ir_drive !== 2'b00) begin errors++; $display("FAIL midreset_async: got %0d ch%0d drv=%b expected 0 ch0 00", bus.sample_value, bus.sample_ch, bus.ir_drive); end
        any = 1'b0;
        repeat (3) begin tick(); any |= bus.sample_valid | bus.sweep_done | bus.black[0] | bus.black[1]; end
        checks++; if (any !== 1'b0) begin errors++; $display("FAIL midreset_no_pulse: got %b expected 0", any); end
        reset = 1'b1;
        run_ch(0, 2, 1'b1, drv, hi, svs, ok);
        checks++; if (!ok || drv !== 2'b01 || hi !== 8) begin errors++; $display("FAIL midreset_restart: got drv=%b hi=%0d expected 01 8", drv, hi); end
        checks++; if (bus.sample_value !== 20'd2 || bus.sample_ch !== 1'b0) begin errors++; $display("FAIL midreset_sample: got %0d ch%0d expected 2 ch0", bus.sample_value, bus.sample_ch); end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.ir_in  = 2'b11;
        test_reset();
        test_basic();
        test_timeout();
        test_debounce();
        test_zero();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
